// File: rtl/upower_pkg.sv
// Shared definitions for the instruction-memory loader and the instruction decoder.
//   - Primary-opcode constants (instruction bits 31:26).
//   - Loader FSM state encoding.
//   - is_supported_op(): true when a primary opcode is one the core implements.
package upower_pkg;

  localparam logic [5:0] OP_XO        = 6'b011111;
  localparam logic [5:0] OP_IMM_DS_LD = 6'b111010;
  localparam logic [5:0] OP_DS_ST     = 6'b111110;
  localparam logic [5:0] OP_BC        = 6'b010011;

  typedef enum logic [2:0] {
    StIdle,
    StLenHi,
    StLenLo,
    StData,
    StWrite
  } loader_state_e;

  function automatic logic is_supported_op(input logic [5:0] op);
    return (op == OP_XO) || (op == OP_IMM_DS_LD) || (op == OP_DS_ST) || (op == OP_BC);
  endfunction

endpackage

// File: rtl/word_packer.sv
// Assembles a 32-bit word from four bytes, first byte landing in bits 31:24.
// Ports:
//   clk_i    - clock
//   rst_ni   - asynchronous active-low reset (clears word and byte count)
//   clear_i  - synchronous clear, discards any partial word
//   shift_i  - accept byte_i this cycle
//   byte_i   - incoming byte
//   word_o   - current shift-register contents
//   last_o   - high when the accepted byte completes a word
module word_packer
  import upower_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        shift_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        last_o
);

  logic [31:0] word_q, word_d;
  logic [1:0]  cnt_q, cnt_d;

  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (clear_i) begin
      word_d = '0;
      cnt_d  = '0;
    end else if (shift_i) begin
      word_d = {word_q[23:0], byte_i};
      cnt_d  = cnt_q + 2'd1;  // wraps to 0 after the 4th byte
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

  assign word_o = word_q;
  assign last_o = shift_i && (cnt_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: receives a big-endian byte stream (16-bit word count,
// then 4 bytes per word) and writes the assembled words to consecutive addresses.
// Ports:
//   clk, reset (async, active-low)
//   start                         - begins a load when idle
//   in_valid/in_byte/in_ready     - host byte stream handshake
//   imem_we/imem_addr/imem_wdata  - instruction-memory write port
//   busy, done, words_written     - load status
//   illegal_op                    - sticky unsupported-opcode flag
// Build option: IMEM_LOADER_OPCODE_CHECK_EN enables the primary-opcode check;
// without it illegal_op is tied low.
module imem_loader
  import upower_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   words_written,
  output logic              illegal_op
);

  localparam int unsigned LenW = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);

  loader_state_e     state_q, state_d;
  logic [7:0]        len_hi_q, len_hi_d;
  logic [LenW-1:0]   len_q, len_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LenW-1:0]   words_q, words_d;
  logic              done_q, done_d;
  logic              load_start;
  logic              pk_shift;
  logic              pk_last;
  logic [31:0]       pk_word;

  assign pk_shift = in_valid && (state_q == StData);

  word_packer u_word_packer (
    .clk_i   (clk),
    .rst_ni  (reset),
    .clear_i (load_start),
    .shift_i (pk_shift),
    .byte_i  (in_byte),
    .word_o  (pk_word),
    .last_o  (pk_last)
  );

  always_comb begin
    state_d    = state_q;
    len_hi_d   = len_hi_q;
    len_d      = len_q;
    addr_d     = addr_q;
    words_d    = words_q;
    done_d     = 1'b0;
    in_ready   = 1'b0;
    imem_we    = 1'b0;
    load_start = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          load_start = 1'b1;
          words_d    = '0;
          addr_d     = BaseAddr;
          state_d    = StLenHi;
        end
      end
      StLenHi: begin
        in_ready = 1'b1;
        if (in_valid) begin
          len_hi_d = in_byte;
          state_d  = StLenLo;
        end
      end
      StLenLo: begin
        in_ready = 1'b1;
        if (in_valid) begin
          // Count is truncated to the width of words_written.
          len_d = LenW'({len_hi_q, in_byte});
          if (len_d == '0) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        in_ready = 1'b1;
        if (pk_last) state_d = StWrite;
      end
      StWrite: begin
        imem_we = 1'b1;
        words_d = words_q + LenW'(1);
        addr_d  = addr_q + ADDR_W'(1);
        if (words_d == len_q) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          state_d = StData;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      len_hi_q <= '0;
      len_q    <= '0;
      addr_q   <= BaseAddr;
      words_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_hi_q <= len_hi_d;
      len_q    <= len_d;
      addr_q   <= addr_d;
      words_q  <= words_d;
      done_q   <= done_d;
    end
  end

`ifdef IMEM_LOADER_OPCODE_CHECK_EN
  logic illegal_q, illegal_d;

  always_comb begin
    illegal_d = illegal_q;
    if (load_start) begin
      illegal_d = 1'b0;
    end else if (imem_we && !is_supported_op(pk_word[31:26])) begin
      illegal_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) illegal_q <= 1'b0;
    else        illegal_q <= illegal_d;
  end

  assign illegal_op = illegal_q;
`else
  assign illegal_op = 1'b0;
`endif

  assign imem_addr     = addr_q;
  assign imem_wdata    = pk_word;
  assign busy          = (state_q != StIdle);
  assign done          = done_q;
  assign words_written = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: two instances (base 0 and base 254) share one stimulus
// stream; a stream-level model predicts every write, status flag and address.
module tb_imem_loader;
  localparam int unsigned AddrW = 8;
  localparam int unsigned BaseA = 0;
  localparam int unsigned BaseB = 254;
  localparam int unsigned AddrMod = 1 << AddrW;
  localparam int unsigned LenMask = (1 << (AddrW + 1)) - 1;
`ifdef IMEM_LOADER_OPCODE_CHECK_EN
  localparam bit ChkEn = 1'b1;
`else
  localparam bit ChkEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, start, in_valid;
  logic [7:0] in_byte;

  logic a_ready, a_we, a_busy, a_done, a_ill;
  logic [AddrW-1:0] a_addr;
  logic [31:0] a_wdata;
  logic [AddrW:0] a_words;
  logic b_ready, b_we, b_busy, b_done, b_ill;
  logic [AddrW-1:0] b_addr;
  logic [31:0] b_wdata;
  logic [AddrW:0] b_words;

  int n_assert = 0;
  int n_fail = 0;
  logic [31:0] words[$];
  bit exp_ill = 1'b0;
  logic [5:0] legal_ops [4] = '{6'h1F, 6'h3A, 6'h3E, 6'h13};

  imem_loader #(.ADDR_W(AddrW), .BASE_ADDR(BaseA)) dut_a (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_byte(in_byte),
    .in_ready(a_ready), .imem_we(a_we), .imem_addr(a_addr), .imem_wdata(a_wdata),
    .busy(a_busy), .done(a_done), .words_written(a_words), .illegal_op(a_ill)
  );

  imem_loader #(.ADDR_W(AddrW), .BASE_ADDR(BaseB)) dut_b (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_byte(in_byte),
    .in_ready(b_ready), .imem_we(b_we), .imem_addr(b_addr), .imem_wdata(b_wdata),
    .busy(b_busy), .done(b_done), .words_written(b_words), .illegal_op(b_ill)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit op_supported(input logic [31:0] w);
    for (int i = 0; i < 4; i++) if (w[31:26] == legal_ops[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(0, 1) == 1) w[31:26] = legal_ops[$urandom_range(0, 3)];
    return w;
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_a_ready"}, a_ready, 0);
    check({tag, "_a_we"}, a_we, 0);
    check({tag, "_a_busy"}, a_busy, 0);
    check({tag, "_a_done"}, a_done, 0);
    check({tag, "_a_ill"}, a_ill, 0);
    check({tag, "_a_words"}, a_words, 0);
    check({tag, "_a_addr"}, a_addr, BaseA);
    check({tag, "_a_wdata"}, a_wdata, 0);
    check({tag, "_b_ready"}, b_ready, 0);
    check({tag, "_b_we"}, b_we, 0);
    check({tag, "_b_busy"}, b_busy, 0);
    check({tag, "_b_done"}, b_done, 0);
    check({tag, "_b_ill"}, b_ill, 0);
    check({tag, "_b_words"}, b_words, 0);
    check({tag, "_b_addr"}, b_addr, BaseB);
    check({tag, "_b_wdata"}, b_wdata, 0);
  endtask

  // Runs one load from a negedge with the loader idle. mode: 0 steady valid,
  // 1 valid alternating, 2 random valid plus random start pulses while busy.
  // abort_after != 0 returns once that many stream bytes have been accepted.
  task automatic load(input logic [15:0] n16, input int mode, input int abort_after);
    int unsigned n_eff;
    logic [7:0] stream[$];
    int sent, wr, cyc;
    bit pend_write, pend_done, fin, wcyc, v, acc;
    n_eff = n16 & LenMask;
    stream.push_back(n16[15:8]);
    stream.push_back(n16[7:0]);
    for (int i = 0; i < int'(n_eff); i++)
      for (int b = 3; b >= 0; b--) stream.push_back(words[i][8*b +: 8]);
    sent = 0; wr = 0; cyc = 0;
    pend_write = 0; pend_done = 0; fin = 0;
    start = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    exp_ill = 1'b0;
    while (!fin) begin
      if (abort_after != 0 && sent == abort_after) begin
        in_valid = 1'b0;
        start = 1'b0;
        return;
      end
      if (cyc > 4000) begin
        n_assert++;
        n_fail++;
        $error("FAIL load_timeout: observed %0d cycles required done within 4000", cyc);
        in_valid = 1'b0;
        start = 1'b0;
        return;
      end
      wcyc = pend_write;
      check("imem_we", a_we, wcyc);
      check("b_imem_we", b_we, wcyc);
      check("words_written", a_words, wr);
      check("illegal_op", a_ill, exp_ill);
      if (pend_done) begin
        check("done", a_done, 1);
        check("busy_end", a_busy, 0);
        check("in_ready_end", a_ready, 0);
        check("words_final", a_words, n_eff);
        in_valid = 1'b0;
        start = 1'b0;
        fin = 1;
      end else begin
        check("done_low", a_done, 0);
        check("busy", a_busy, 1);
        check("in_ready", a_ready, !wcyc);
        if (wcyc) begin
          check("imem_addr", a_addr, (BaseA + wr) % AddrMod);
          check("b_imem_addr", b_addr, (BaseB + wr) % AddrMod);
          check("imem_wdata", a_wdata, words[wr]);
          if (ChkEn && !op_supported(words[wr])) exp_ill = 1'b1;
          wr++;
          pend_write = 0;
          if (wr == int'(n_eff)) pend_done = 1;
        end
        case (mode)
          0:       v = 1'b1;
          1:       v = (cyc % 2) == 0;
          default: v = 1'($urandom_range(0, 1));
        endcase
        acc = v && !wcyc && (sent < stream.size());
        in_valid = v;
        in_byte = (sent < stream.size()) ? stream[sent] : 8'($urandom);
        if (acc) begin
          sent++;
          if (sent == 2 && n_eff == 0) pend_done = 1;
          if (sent > 2 && (sent - 2) % 4 == 0) pend_write = 1;
        end
        start = (mode == 2 && !pend_done) ? 1'($urandom_range(0, 1)) : 1'b0;
        cyc++;
        @(negedge clk);
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    in_byte = 8'h00;
    repeat (2) @(negedge clk);
    check_reset_vals("por");
    reset = 1'b1;
    // Valid bytes offered before start must not be consumed.
    in_valid = 1'b1;
    in_byte = 8'hA5;
    repeat (3) begin
      @(negedge clk);
      check("idle_busy", a_busy, 0);
      check("idle_ready", a_ready, 0);
      check("idle_we", a_we, 0);
    end
    in_valid = 1'b0;

    words = {32'h7C221A14, 32'hE8410008};
    load(16'd2, 0, 0);

    words = {32'h4C000020};
    load(16'd1, 1, 0);

    words = {32'h00000000, 32'h7C000000};
    load(16'd2, 2, 0);
    repeat (3) begin
      @(negedge clk);
      check("ill_held", a_ill, ChkEn);
    end
    words = {32'h4C000020};
    load(16'd1, 0, 0);

    // Three words: base-254 instance writes 254, 255, 0.
    words = {32'h7C000001, 32'hE8000002, 32'hF8000003};
    load(16'd3, 0, 0);

    // Count truncation: 0x0201 -> 1 word, 0x0200 -> 0 words.
    words = {32'h4C000001};
    load(16'h0201, 2, 0);
    load(16'h0200, 0, 0);
    load(16'd0, 2, 0);

    for (int k = 0; k < 6; k++) begin
      int unsigned n;
      n = $urandom_range(1, 6);
      words.delete();
      for (int i = 0; i < int'(n); i++) words.push_back(rand_word());
      load(16'(n), 2, 0);
    end

    // Reset after two data bytes, then a fresh single-word load.
    words = {32'hDEADBEEF};
    load(16'd1, 0, 4);
    #2 reset = 1'b0;
    #1 check_reset_vals("midload");
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b1;
    in_byte = 8'h3C;
    repeat (2) begin
      @(negedge clk);
      check("post_rst_busy", a_busy, 0);
      check("post_rst_words", a_words, 0);
    end
    in_valid = 1'b0;
    words = {32'h7C0802A6};
    load(16'd1, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, instruction-memory word-address width.
REQ-002 SHALL have parameter BASE_ADDR, default 0, first word address written.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle pulse; begins a load when idle.
REQ-006 SHALL have port in_valid  input  1  host byte valid.
REQ-007 SHALL have port in_byte  input  8  host byte, big-endian stream.
REQ-008 SHALL have port in_ready  output  1  loader accepts byte this cycle.
REQ-009 SHALL have port imem_we  output  1  instruction-memory write strobe.
REQ-010 SHALL have port imem_addr  output  ADDR_W  word write address.
REQ-011 SHALL have port imem_wdata  output  32  assembled instruction word.
REQ-012 SHALL have port busy  output  1  load in progress.
REQ-013 SHALL have port done  output  1  one-cycle pulse when the last word is written.
REQ-014 SHALL have port words_written  output  ADDR_W+1  words written in the current or last load.
REQ-015 SHALL have port illegal_op  output  1  sticky; a word with an unsupported primary opcode was written.

Function
REQ-016 SHALL implement FSM states IDLE, LEN_HI, LEN_LO, DATA, WRITE.
REQ-017 IDLE: in_ready=0, busy=0; start -> LEN_HI, clear words_written and illegal_op, set address to BASE_ADDR.
REQ-018 A byte SHALL transfer only in a cycle where in_valid=1 and in_ready=1; in_ready=1 only in LEN_HI, LEN_LO and DATA.
REQ-019 LEN_HI/LEN_LO SHALL capture a 16-bit word count N, high byte first; N is truncated to ADDR_W+1 bits.
REQ-020 If N=0 after LEN_LO, the FSM SHALL pulse done and return to IDLE with no memory write.
REQ-021 DATA SHALL shift in 4 bytes MSB-first (first byte -> bits 31:24); after the 4th byte -> WRITE.
REQ-022 WRITE SHALL last exactly one cycle with imem_we=1 and in_ready=0; imem_addr and imem_wdata are stable for that cycle; words_written increments.
REQ-023 After WRITE, the address SHALL increment modulo 2^ADDR_W (wrap from all-ones to 0); if words_written equals N -> IDLE with done=1 in the same cycle, else -> DATA.
REQ-024 Latency from the accepted 4th byte of a word to imem_we SHALL be 1 cycle.
REQ-025 in_valid gaps SHALL stall the FSM with no state change; partial words are retained.
REQ-026 start SHALL be ignored while busy=1.
REQ-027 imem_we SHALL be 0 in every state other than WRITE.

Reset
REQ-028 Asserting reset, including mid-load, SHALL immediately force IDLE with in_ready=0, imem_we=0, busy=0, done=0, illegal_op=0, words_written=0, imem_addr=BASE_ADDR, imem_wdata=0; the partial word is discarded.
REQ-029 After reset deassertion, the loader SHALL wait for start; no byte is consumed first.

Configuration
REQ-030 Macro IMEM_LOADER_OPCODE_CHECK_EN defined: in WRITE, bits 31:26 not in {011111, 111010, 111110, 010011} SHALL set illegal_op; the word is still written.
REQ-031 Macro undefined: illegal_op SHALL be tied to 0 and no check logic is instantiated.

Structure
REQ-032 Package upower_pkg SHALL hold the primary-opcode constants (OP_XO=011111, OP_IMM_DS_LD=111010, OP_DS_ST=111110, OP_BC=010011) and the loader state enum; the instruction decoder shares these constants.
REQ-033 One sub-module, word_packer (4-byte shift register plus 2-bit byte counter), is natural; FSM, address and length logic stay in imem_loader.

Verification
REQ-034 Reset, start, N=2, bytes 7C 22 1A 14 E8 41 00 08 -> writes 0x7C221A14 @0 then 0xE8410008 @1; done one cycle after the second imem_we; illegal_op=0.
REQ-035 N=1, in_valid toggled 1/0 every cycle -> single write 0x4C000020 @BASE_ADDR; no write or state change in idle-valid cycles.
REQ-036 With the macro defined, word 0x00000000 -> written and illegal_op=1 held until the next start; with the macro undefined -> illegal_op=0.
REQ-037 BASE_ADDR=254, ADDR_W=8, N=3 -> writes at 254, 255, 0.
REQ-038 Reset asserted after 2 data bytes -> outputs take reset values asynchronously; a new start with N=1 writes a fresh word with no stale bytes.
REQ-039 N=0 -> done pulse, no imem_we; start during busy -> ignored, words_written unaffected.
